gray_run_ctrl: RTL and testbench

//  Sequencer for an external GREY_COUNT instance. Accepts run commands (clear + N steps)

---
 rtl/gray_run_ctrl_pkg.sv | 17 +
 rtl/gray_run_ctrl_if.sv | 12 +
 rtl/gray_run_ctrl_step_check.sv | 47 ++++
 rtl/gray_run_ctrl.sv | 124 ++++++++++++
 tb/tb_gray_run_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/gray_run_ctrl_pkg.sv
// Shared definitions for the Gray counter run sequencer: FSM encodings and the
// single-bit-change helper used by the step checker.
package gray_run_ctrl_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] S_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] S_CLEAR = 2'd1;
  localparam logic [STATE_W-1:0] S_RUN   = 2'd2;
  localparam logic [STATE_W-1:0] S_DONE  = 2'd3;

  // True when exactly one bit of x is set.
  function automatic logic one_bit_set(input logic [31:0] x);
    return (x != 32'd0) && ((x & (x - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/gray_run_ctrl_if.sv
// Host command channel of the Gray run sequencer: valid/ready plus length and clear flag.
interface gray_run_ctrl_if #(
  parameter int LEN_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [LEN_W-1:0] cmd_len;
  logic             cmd_clear;

  modport master (output cmd_valid, output cmd_len, output cmd_clear, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_len, input cmd_clear, output cmd_ready);
endinterface

// File: rtl/gray_run_ctrl_step_check.sv
// Watches the external Gray counter one cycle after each control action and flags
// any update that is not a clear-to-zero, a single-bit step, or a hold.
module gray_run_ctrl_step_check
  import gray_run_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] gray_count_i,
  input  logic             cnt_enable_i,
  input  logic             cnt_reset_i,
  input  logic             busy_i,
  output logic             step_bad_o
);

  logic [WIDTH-1:0] prev_g_q;
  logic             en_q;
  logic             clr_q;
  logic [WIDTH-1:0] diff;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_g_q <= '0;
      en_q     <= 1'b0;
      clr_q    <= 1'b0;
    end else begin
      prev_g_q <= gray_count_i;
      en_q     <= cnt_enable_i;
      clr_q    <= cnt_reset_i;
    end
  end

  assign diff = prev_g_q ^ gray_count_i;

  always_comb begin
    step_bad_o = 1'b0;
    if (clr_q) begin
      step_bad_o = (gray_count_i != '0);
    end else if (en_q) begin
      step_bad_o = !one_bit_set(32'(diff));
    end else if (busy_i) begin
      step_bad_o = (diff != '0);
    end
  end

endmodule

// File: rtl/gray_run_ctrl.sv
// Run sequencer for an external Gray counter: accepts clear+N-step commands, drives
// counter enable/reset with pause and abort, and reports done/aborted/gray_err.
module gray_run_ctrl
  import gray_run_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  gray_run_ctrl_if.slave   cmd_if,
  input  logic             pause_i,
  input  logic             abort_i,
  output logic             cnt_enable_o,
  output logic             cnt_reset_o,
  input  logic [WIDTH-1:0] gray_count_i,
  output logic             busy_o,
  output logic [LEN_W-1:0] steps_o,
  output logic             done_o,
  output logic             aborted_o,
  output logic             gray_err_o
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [LEN_W-1:0]   remaining_q, remaining_d;
  logic [LEN_W-1:0]   steps_q, steps_d;
  logic               cnt_reset_q, cnt_reset_d;
  logic               aborted_q, aborted_d;
  logic               gray_err_q, gray_err_d;
  logic               accept;
  logic               step_bad;

  assign cmd_if.cmd_ready = (state_q == S_IDLE);
  assign accept           = cmd_if.cmd_valid && (state_q == S_IDLE);
  assign cnt_enable_o     = (state_q == S_RUN) && !pause_i && !abort_i;
  // The counter is held clear while the sequencer itself is in reset.
  assign cnt_reset_o      = cnt_reset_q || reset;
  assign busy_o           = (state_q != S_IDLE);
  assign steps_o          = steps_q;
  assign done_o           = (state_q == S_DONE);
  assign aborted_o        = aborted_q;
  assign gray_err_o       = gray_err_q;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    steps_d     = steps_q;
    cnt_reset_d = 1'b0;
    aborted_d   = 1'b0;
    gray_err_d  = gray_err_q || step_bad;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          remaining_d = cmd_if.cmd_len;
          steps_d     = '0;
          gray_err_d  = 1'b0;
          if (cmd_if.cmd_clear) begin
            state_d     = S_CLEAR;
            cnt_reset_d = 1'b1;
          end else if (cmd_if.cmd_len == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_CLEAR: begin
        if (abort_i) begin
          state_d   = S_IDLE;
          aborted_d = 1'b1;
        end else if (remaining_q == '0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (abort_i) begin
          state_d   = S_IDLE;
          aborted_d = 1'b1;
        end else if (!pause_i) begin
          remaining_d = remaining_q - LEN_W'(1);
          steps_d     = steps_q + LEN_W'(1);
          if (remaining_q == LEN_W'(1)) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      steps_q     <= '0;
      cnt_reset_q <= 1'b0;
      aborted_q   <= 1'b0;
      gray_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      steps_q     <= steps_d;
      cnt_reset_q <= cnt_reset_d;
      aborted_q   <= aborted_d;
      gray_err_q  <= gray_err_d;
    end
  end

  gray_run_ctrl_step_check #(
    .WIDTH(WIDTH)
  ) u_step_check (
    .clk          (clk),
    .reset        (reset),
    .gray_count_i (gray_count_i),
    .cnt_enable_i (cnt_enable_o),
    .cnt_reset_i  (cnt_reset_q),
    .busy_i       (busy_o),
    .step_bad_o   (step_bad)
  );

endmodule

// File: tb/tb_gray_run_ctrl.sv
// Directed bench for gray_run_ctrl driving a behavioural Gray counter.
module tb_gray_run_ctrl;
  localparam int WIDTH = 8;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             pause = 1'b0;
  logic             abort = 1'b0;
  logic             cnt_enable;
  logic             cnt_reset;
  logic [WIDTH-1:0] gray_count;
  logic             busy;
  logic [LEN_W-1:0] steps;
  logic             done;
  logic             aborted;
  logic             gray_err;

  gray_run_ctrl_if #(.LEN_W(LEN_W)) cmd_if ();

  gray_run_ctrl #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_if       (cmd_if.slave),
    .pause_i      (pause),
    .abort_i      (abort),
    .cnt_enable_o (cnt_enable),
    .cnt_reset_o  (cnt_reset),
    .gray_count_i (gray_count),
    .busy_o       (busy),
    .steps_o      (steps),
    .done_o       (done),
    .aborted_o    (aborted),
    .gray_err_o   (gray_err)
  );

  always #5 clk = ~clk;

  // Gray counter model; inj replaces the 0x02 code with 0x00 (a 3 -> 0 jump).
  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] model_gray;
  logic             inj = 1'b0;
  always @(posedge clk) begin
    if (cnt_reset) bin_q <= '0;
    else if (cnt_enable) bin_q <= bin_q + 1'b1;
  end
  assign model_gray = bin_q ^ (bin_q >> 1);
  assign gray_count = (inj && model_gray == 8'h02) ? 8'h00 : model_gray;

  int n_en = 0, n_rst = 0, n_done = 0, n_abt = 0;
  always @(posedge clk) begin
    if (cnt_enable === 1'b1) n_en++;
    if (cnt_reset === 1'b1) n_rst++;
    if (done === 1'b1) n_done++;
    if (aborted === 1'b1) n_abt++;
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [LEN_W-1:0] len, input logic clr);
    int n = 0;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_len   = len;
    cmd_if.cmd_clear = clr;
    while (!cmd_if.cmd_ready && n < 50) begin
      tick();
      n++;
    end
    check_val("ready_timeout", {31'd0, cmd_if.cmd_ready}, 32'd1);
    tick();
    cmd_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (busy && n < bound) begin
      tick();
      n++;
    end
    check_val("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  int base_en, base_rst, base_done, base_abt, cyc;

  initial begin
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_len   = '0;
    cmd_if.cmd_clear = 1'b0;

    tick();
    tick();
    check_val("rst_cnt_reset", {31'd0, cnt_reset}, 32'd1);
    check_val("rst_enable", {31'd0, cnt_enable}, 32'd0);
    reset = 1'b0;
    tick();
    check_val("rst_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_steps", {24'd0, steps}, 32'd0);
    check_val("rst_flags", {29'd0, done, aborted, gray_err}, 32'd0);
    check_val("rst_cnt_reset_rel", {31'd0, cnt_reset}, 32'd0);

    // len=5 with clear
    base_en = n_en; base_rst = n_rst; base_done = n_done;
    send_cmd(8'd5, 1'b1);
    check_val("t1_clear_pulse", {31'd0, cnt_reset}, 32'd1);
    wait_idle(50);
    check_val("t1_enables", n_en - base_en, 32'd5);
    check_val("t1_rst_pulses", n_rst - base_rst, 32'd1);
    check_val("t1_done_pulses", n_done - base_done, 32'd1);
    check_val("t1_gray", {24'd0, gray_count}, 32'h07);
    check_val("t1_steps", {24'd0, steps}, 32'd5);
    check_val("t1_err", {31'd0, gray_err}, 32'd0);

    // len=0 without clear
    base_en = n_en;
    send_cmd(8'd0, 1'b0);
    check_val("t2_done", {31'd0, done}, 32'd1);
    check_val("t2_ready_in_done", {31'd0, cmd_if.cmd_ready}, 32'd0);
    tick();
    check_val("t2_done_gone", {31'd0, done}, 32'd0);
    check_val("t2_enables", n_en - base_en, 32'd0);
    check_val("t2_steps", {24'd0, steps}, 32'd0);

    // len=10, pause for 3 cycles after 3 steps
    base_en = n_en;
    send_cmd(8'd10, 1'b0);
    tick(); tick(); tick();
    pause = 1'b1;
    tick();
    check_val("t3_paused_en", {31'd0, cnt_enable}, 32'd0);
    check_val("t3_paused_steps", {24'd0, steps}, 32'd3);
    tick(); tick();
    pause = 1'b0;
    cyc = 7;
    while (!done && cyc < 40) begin
      tick();
      cyc++;
    end
    check_val("t3_done_cycle", cyc, 32'd14);
    tick();
    check_val("t3_enables", n_en - base_en, 32'd10);
    check_val("t3_gray", {24'd0, gray_count}, 32'h08);

    // len=20 with clear, abort after 4 steps
    base_done = n_done; base_abt = n_abt;
    send_cmd(8'd20, 1'b1);
    tick(); tick(); tick(); tick(); tick();
    abort = 1'b1;
    #1;
    check_val("t4_abort_en", {31'd0, cnt_enable}, 32'd0);
    check_val("t4_steps_pre", {24'd0, steps}, 32'd4);
    tick();
    abort = 1'b0;
    check_val("t4_aborted", {31'd0, aborted}, 32'd1);
    check_val("t4_busy", {31'd0, busy}, 32'd0);
    tick();
    check_val("t4_abt_pulses", n_abt - base_abt, 32'd1);
    check_val("t4_no_done", n_done - base_done, 32'd0);
    check_val("t4_steps", {24'd0, steps}, 32'd4);
    check_val("t4_gray", {24'd0, gray_count}, 32'h06);

    // len=255 with clear, then len=2 without clear across the wrap
    base_en = n_en;
    send_cmd(8'd255, 1'b1);
    wait_idle(400);
    check_val("t5_steps_max", {24'd0, steps}, 32'd255);
    check_val("t5_gray_max", {24'd0, gray_count}, 32'h80);
    send_cmd(8'd2, 1'b0);
    wait_idle(50);
    check_val("t5_enables", n_en - base_en, 32'd257);
    check_val("t5_gray_wrap", {24'd0, gray_count}, 32'h01);
    check_val("t5_err", {31'd0, gray_err}, 32'd0);

    // corrupted counter step must raise gray_err, cleared on next accept
    inj = 1'b1;
    send_cmd(8'd5, 1'b1);
    wait_idle(50);
    inj = 1'b0;
    tick();
    check_val("t6_err_set", {31'd0, gray_err}, 32'd1);
    send_cmd(8'd0, 1'b0);
    check_val("t6_err_clear", {31'd0, gray_err}, 32'd0);
    tick();

    // reset in the middle of a run
    base_done = n_done; base_abt = n_abt;
    send_cmd(8'd10, 1'b0);
    tick(); tick();
    reset = 1'b1;
    tick();
    check_val("t7_busy", {31'd0, busy}, 32'd0);
    check_val("t7_cnt_reset", {31'd0, cnt_reset}, 32'd1);
    reset = 1'b0;
    tick();
    check_val("t7_no_pulses", (n_done - base_done) + (n_abt - base_abt), 32'd0);
    check_val("t7_steps", {24'd0, steps}, 32'd0);
    check_val("t7_gray", {24'd0, gray_count}, 32'h00);
    check_val("t7_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
